fc_output_layer: RTL and testbench
==================================

# fc_output_layer

Final fully-connected stage of the classifier. Consumes the flattened feature vector one signed Q8.8 word at a time, multiplies it against a weight row fetched from an external synchronous ROM, and accumulates NUM_CLASSES class scores. Adds biases, scales and saturates the scores, then presents them as the score array for the downstream argmax comparator with a one-cycle `done` pulse.

## Interface
- `IN_LEN`, 32: number of input features per inference; 1..256.
- `NUM_CLASSES`, 10: number of class scores.
- `DATA_W`, 16: width of features, weights, biases and scores (signed Q8.8).
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins an inference when the block is idle.
- `in_valid`  in  1  `in_data` valid.
- `in_data`  in  DATA_W  feature word, signed Q8.8.
- `in_ready`  out  1  block accepts a feature this cycle.
- `w_addr`  out  9  ROM row address; rows 0..IN_LEN-1 hold weights, row IN_LEN holds biases.
- `w_data`  in  DATA_W*NUM_CLASSES  ROM row; class c in bits [c*DATA_W +: DATA_W]; valid exactly one cycle after `w_addr`.
- `scores`  out  DATA_W*NUM_CLASSES  registered class scores, same packing as `w_data`.
- `scores_valid`  out  1  level; `scores` holds a complete result.
- `busy`  out  1  inference in progress.
- `done`  out  1  one-cycle pulse when `scores` updates.

## Operation
- FSM states: IDLE, LOAD, BIAS, ADD_BIAS, OUT.
- IDLE: `in_ready`=0. If `start`=1, clear all NUM_CLASSES accumulators and the feature counter k, drop `scores_valid`, and go to LOAD.
- LOAD: `in_ready`=1 and `w_addr`=k. On a handshake (`in_valid`&`in_ready`), register the feature and increment k. On the next cycle, acc[c] += x*w[c] for every class in parallel. Gaps in `in_valid` are allowed and cause no MAC. The handshake with k=IN_LEN-1 moves the FSM to BIAS.
- BIAS: `in_ready`=0 and `w_addr`=IN_LEN. The MAC for the last feature completes in this cycle. Go to ADD_BIAS.
- ADD_BIAS: acc[c] += sign-extended bias[c]<<8, which aligns Q8.8 to Q16.16. Go to OUT.
- OUT: scores[c] = acc[c]>>>8, with saturation per Configuration. Set `scores_valid`=1, pulse `done`, and go to IDLE.
- Arithmetic:
  - Product is a 32-bit signed Q16.16 value.
  - Accumulators are 40-bit signed, so no overflow is possible for IN_LEN≤256.
  - The right shift truncates toward −∞. There is no rounding.
- Boundary behaviour:
  - `start` outside IDLE is ignored.
  - `in_valid` outside LOAD is not accepted.
  - `start` and `in_valid` in the same IDLE cycle: the block starts, but the feature is not accepted until the next cycle.
  - `scores` holds its value until the next `start`.
  - `reset` asserted at any time immediately forces IDLE and clears all registers, including the accumulators.
- `w_addr` in IDLE and OUT is 0.

## Timing
- Reset values: `in_ready`=0, `w_addr`=0, `scores`=0, `scores_valid`=0, `busy`=0, `done`=0.
- `busy`=1 in LOAD, BIAS, ADD_BIAS and OUT.
- ROM read latency is exactly 1 cycle, and the block never stalls the ROM.
- Latency: if the last feature handshake is at edge T, then `scores`, `scores_valid` and `done` update at edge T+3. `done` is high for exactly one cycle.
- Throughput: one feature per cycle. The minimum inference is 1 (start) + IN_LEN + 3 cycles.

## Configuration
- `FC_SAT_EN` defined: each score saturates to [0x8000, 0x7FFF] when acc>>>8 exceeds the signed 16-bit range.
- `FC_SAT_EN` undefined: each score is the low DATA_W bits of acc>>>8, so out-of-range values wrap. No saturation logic is built.

## Test plan
- Basic inference:
  - Stimulus: IN_LEN=4; four features of 0x0100 back-to-back; w[c]=c*0x0100; bias 0.
  - Required: scores[c]=c*0x0400 (class 9 = 0x2400); `done` pulses 3 cycles after the 4th handshake.
- Bias and bubbles:
  - Stimulus: as basic inference, but with `in_valid` toggling 1,0,1,0 and bias[c]=0xFF00 (−1.0).
  - Required: scores[c]=c*0x0400−0x0100 (class 0 = 0xFF00).
- Overflow, with `FC_SAT_EN`:
  - Stimulus: IN_LEN=4; x=w=0x7F00 for all terms.
  - Required: all scores are 0x7FFF.
  - Stimulus: w=0x8100 instead.
  - Required: all scores are 0x8000.
- Overflow, without `FC_SAT_EN`:
  - Stimulus: x=w=0x7F00, IN_LEN=4.
  - Required: all scores are 0x0400.
- Control robustness:
  - Stimulus: assert `start` during LOAD.
  - Required: ignored; the result is unchanged.
  - Stimulus: then drop `reset` after 2 features.
  - Required: all outputs return to reset values with no `done`. A new full inference then gives the basic-inference result.
- Hold and restart:
  - Check: after `done`, `scores` and `scores_valid` stay stable for 20 idle cycles.
  - Stimulus: next `start`.
  - Required: `scores_valid` drops the following cycle.

Source files
------------

// File: rtl/fc_output_layer.sv
// fc_output_layer: final fully-connected classifier stage.
// Streams IN_LEN signed Q8.8 features and multiplies each one against a weight
// row read from an external 1-cycle synchronous ROM. It accumulates NUM_CLASSES
// Q16.16 sums, adds the biases from ROM row IN_LEN, and registers Q8.8 scores.
// Optional feature: define FC_SAT_EN to saturate scores instead of wrapping.
module fc_output_layer #(
    parameter int IN_LEN      = 32,
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    output logic [8:0]                    w_addr,
    input  logic [DATA_W*NUM_CLASSES-1:0] w_data,
    output logic [DATA_W*NUM_CLASSES-1:0] scores,
    output logic                          scores_valid,
    output logic                          busy,
    output logic                          done
);

    localparam int ACC_W  = 40;
    localparam int PROD_W = 2 * DATA_W;
    localparam int FRAC_W = 8;
    localparam logic [8:0] K_LAST    = 9'(IN_LEN - 1);
    localparam logic [8:0] BIAS_ADDR = 9'(IN_LEN);

    typedef enum logic [2:0] {IDLE, LOAD, BIAS, ADD_BIAS, OUT} state_t;

    state_t                    state, state_nxt;
    logic [8:0]                k;
    logic signed [DATA_W-1:0]  x_q;
    logic                      mac_pending;
    logic                      handshake;
    logic                      start_accept;
    logic signed [ACC_W-1:0]   acc      [NUM_CLASSES];
    logic signed [PROD_W-1:0]  prod     [NUM_CLASSES];
    logic [DATA_W*NUM_CLASSES-1:0] scores_nxt;

    assign handshake    = in_valid & in_ready;
    assign start_accept = (state == IDLE) & start;
    assign busy         = (state != IDLE);

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state, handshake and ROM address decode.
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        w_addr    = '0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                w_addr   = k;
                if (in_valid && (k == K_LAST)) state_nxt = BIAS;
            end
            BIAS: begin
                w_addr    = BIAS_ADDR;
                state_nxt = ADD_BIAS;
            end
            ADD_BIAS: state_nxt = OUT;
            OUT:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Feature capture: the feature waits one cycle for its ROM row to arrive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k           <= '0;
            x_q         <= '0;
            mac_pending <= 1'b0;
        end else begin
            mac_pending <= handshake;
            if (start_accept) begin
                k <= '0;
            end else if (handshake) begin
                k   <= k + 9'd1;
                x_q <= $signed(in_data);
            end
        end
    end

    // Per-class Q8.8 x Q8.8 products, giving Q16.16.
    always_comb begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
            prod[c] = x_q * $signed(w_data[c*DATA_W +: DATA_W]);
        end
    end

    // Accumulators: MAC one cycle after each handshake, then the aligned bias.
    // NOTE: the accumulator array is reset as well, because an aborted
    // inference must not leave partial sums visible after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= '0;
        end else if (start_accept) begin
            for (int c = 0; c < NUM_CLASSES; c++) acc[c] <= '0;
        end else if (mac_pending) begin
            for (int c = 0; c < NUM_CLASSES; c++)
                acc[c] <= acc[c] + {{(ACC_W-PROD_W){prod[c][PROD_W-1]}}, prod[c]};
        end else if (state == ADD_BIAS) begin
            for (int c = 0; c < NUM_CLASSES; c++)
                acc[c] <= acc[c] + {{(ACC_W-DATA_W-FRAC_W){w_data[c*DATA_W+DATA_W-1]}},
                                    w_data[c*DATA_W +: DATA_W], {FRAC_W{1'b0}}};
        end
    end

    // Rescale Q16.16 to Q8.8 by truncation toward -inf, then saturate or wrap.
    always_comb begin
        scores_nxt = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
`ifdef FC_SAT_EN
            if (!(&acc[c][ACC_W-1:FRAC_W+DATA_W-1]) && (|acc[c][ACC_W-1:FRAC_W+DATA_W-1])) begin
                scores_nxt[c*DATA_W +: DATA_W] = acc[c][ACC_W-1] ?
                    {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
            end else begin
                scores_nxt[c*DATA_W +: DATA_W] = acc[c][FRAC_W +: DATA_W];
            end
`else
            scores_nxt[c*DATA_W +: DATA_W] = acc[c][FRAC_W +: DATA_W];
`endif
        end
    end

    // Result registers: scores hold until the next start; done pulses once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scores       <= '0;
            scores_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= (state == OUT);
            if (start_accept) begin
                scores_valid <= 1'b0;
            end else if (state == OUT) begin
                scores       <= scores_nxt;
                scores_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fc_output_layer.sv
// Testbench for fc_output_layer (IN_LEN=4). The stimulus pushes expected score
// vectors into a scoreboard queue, and a monitor pops and compares them on done.
// The expected scores come from a plain-integer model of the layer arithmetic.
module tb_fc_output_layer;

    localparam int IN_LEN = 4;
    localparam int NC     = 10;
    localparam int DW     = 16;
    localparam int VW     = NC * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic [8:0]    w_addr;
    logic [VW-1:0] w_data = '0;
    logic [VW-1:0] scores;
    logic          scores_valid;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_hs_cyc = 0;
    logic done_prev = 1'b0;

    logic [VW-1:0] rom  [0:IN_LEN];
    logic [DW-1:0] feat [IN_LEN];
    logic [VW-1:0] sb [$];
    logic [VW-1:0] last_exp = '0;

    fc_output_layer #(.IN_LEN(IN_LEN), .NUM_CLASSES(NC), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .w_addr(w_addr), .w_data(w_data),
        .scores(scores), .scores_valid(scores_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) w_data <= (w_addr <= 9'(IN_LEN)) ? rom[w_addr] : '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: dot product plus bias in plain integers, floor-divided by 256.
    function automatic logic [VW-1:0] model();
        logic [VW-1:0] r = '0;
        for (int c = 0; c < NC; c++) begin
            longint acc = 0;
            longint s;
            for (int i = 0; i < IN_LEN; i++)
                acc += longint'($signed(feat[i])) * longint'($signed(rom[i][c*DW +: DW]));
            acc += longint'($signed(rom[IN_LEN][c*DW +: DW])) * 256;
            s = acc >>> 8;
`ifdef FC_SAT_EN
            if (s > 32767)       s = 32767;
            else if (s < -32768) s = -32768;
`endif
            r[c*DW +: DW] = s[15:0];
        end
        return r;
    endfunction

    // Monitor: every done must match the oldest expected vector, 3 cycles late.
    always @(negedge clk) begin
        if (done) begin
            check("done_single_cycle", done_prev, 0);
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                logic [VW-1:0] exp;
                exp = sb.pop_front();
                for (int c = 0; c < NC; c++)
                    check($sformatf("score[%0d]", c), scores[c*DW +: DW], exp[c*DW +: DW]);
                check("scores_valid_at_done", scores_valid, 1);
                check("done_latency", cyc - last_hs_cyc, 3);
            end
        end
        done_prev <= done;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_w_addr"}, w_addr, 0);
        check({tag, "_scores"}, scores, 0);
        check({tag, "_scores_valid"}, scores_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // Present one feature and hold it until the DUT takes it (bounded wait).
    task automatic feed(input logic [DW-1:0] x, input bit poke_start);
        bit hs = 0;
        int n  = 0;
        in_valid = 1'b1;
        in_data  = x;
        start    = poke_start;
        while (!hs && n < 20) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) check("handshake_timeout", hs, 1);
        last_hs_cyc = cyc;
        in_valid = 1'b0;
        start    = 1'b0;
        in_data  = DW'($urandom);
    endtask

    task automatic do_start(input bit overlap, input bit check_drop);
        start = 1'b1;
        if (overlap) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        if (check_drop) begin
            check("scores_valid_drop", scores_valid, 0);
            check("busy_after_start", busy, 1);
        end
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle after each feature, 2 random gaps.
    task automatic run_inf(input int gap_mode, input bit overlap, input bit poke_start,
                           input bit check_drop);
        logic [VW-1:0] exp;
        int n = 0;
        exp = model();
        sb.push_back(exp);
        last_exp = exp;
        do_start(overlap, check_drop);
        for (int i = 0; i < IN_LEN; i++) begin
            feed(feat[i], poke_start);
            if (gap_mode == 1) begin
                @(posedge clk); #1;
            end else if (gap_mode == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
        end
        while (sb.size() != 0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", sb.size(), 0);
        sb.delete();
    endtask

    task automatic set_basic(input logic [DW-1:0] bias);
        for (int i = 0; i < IN_LEN; i++) begin
            feat[i] = 16'h0100;
            for (int c = 0; c < NC; c++) rom[i][c*DW +: DW] = DW'(c * 16'h0100);
        end
        for (int c = 0; c < NC; c++) rom[IN_LEN][c*DW +: DW] = bias;
    endtask

    task automatic set_uniform(input logic [DW-1:0] x, input logic [DW-1:0] w);
        for (int i = 0; i < IN_LEN; i++) begin
            feat[i] = x;
            for (int c = 0; c < NC; c++) rom[i][c*DW +: DW] = w;
        end
        for (int c = 0; c < NC; c++) rom[IN_LEN][c*DW +: DW] = '0;
    endtask

    function automatic logic [DW-1:0] rnd_word();
        if ($urandom_range(0, 1) == 1) return DW'($urandom);
        return DW'(int'($urandom_range(0, 2047)) - 1024);
    endfunction

    initial begin
        for (int r = 0; r <= IN_LEN; r++) rom[r] = '0;
        for (int i = 0; i < IN_LEN; i++) feat[i] = '0;

        // Power-on reset.
        #1 reset = 1'b0;
        #3;
        check_reset_outputs("por");
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #1;

        // Basic inference, then bias with bubbles.
        set_basic(16'h0000);
        run_inf(0, 0, 0, 0);
        set_basic(16'hFF00);
        run_inf(1, 0, 0, 0);

        // Large products: saturate or wrap depending on the build.
        set_uniform(16'h7F00, 16'h7F00);
        run_inf(0, 0, 0, 0);
        set_uniform(16'h7F00, 16'h8100);
        run_inf(0, 0, 0, 0);

        // start held during LOAD is ignored; start+in_valid in IDLE takes no feature.
        set_basic(16'h0000);
        run_inf(0, 1, 1, 0);

        // Reset after two features: outputs clear and no done appears.
        do_start(0, 0);
        feed(feat[0], 0);
        feed(feat[1], 0);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("midrun");
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("abort_no_valid", scores_valid, 0);
        run_inf(0, 0, 0, 0);

        // Hold for 20 idle cycles, then restart drops scores_valid.
        repeat (20) begin
            @(posedge clk); #1;
            check("hold_scores", scores, last_exp);
            check("hold_valid", scores_valid, 1);
        end
        set_basic(16'h0100);
        run_inf(0, 0, 0, 1);

        // Randomized inferences.
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < IN_LEN; i++) begin
                feat[i] = rnd_word();
                for (int c = 0; c < NC; c++) rom[i][c*DW +: DW] = rnd_word();
            end
            for (int c = 0; c < NC; c++) rom[IN_LEN][c*DW +: DW] = rnd_word();
            run_inf(int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)),
                    bit'($urandom_range(0, 1)), 1);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
